// File: rtl/vsync_frame_detector_if.sv
// vsync_frame_detector_if: sync inputs, run control and frame outputs
// grouped for the frame detector; master drives, slave is the detector.
interface vsync_frame_detector_if #(
  parameter int IDX_W  = 2,
  parameter int LINE_W = 12
);
  logic              vsync_in;
  logic              hsync_in;
  logic              enable;
  logic              err_clr;
  logic              frame_pulse;
  logic [IDX_W-1:0]  frame_idx;
  logic [LINE_W-1:0] line_cnt_last;
  logic              locked;
  logic              frame_err;

  modport master (
    output vsync_in, hsync_in, enable, err_clr,
    input  frame_pulse, frame_idx, line_cnt_last, locked, frame_err
  );

  modport slave (
    input  vsync_in, hsync_in, enable, err_clr,
    output frame_pulse, frame_idx, line_cnt_last, locked, frame_err
  );
endinterface

// File: rtl/vsync_frame_detector.sv
// vsync_frame_detector: rebuilds frame starts from vsync/hsync timing.
// Macro VSYNC_FRAME_DET_LINE_CHECK_EN enables line-count lock checking.
module vsync_frame_detector #(
  parameter int NUM_FRAMES        = 3,
  parameter int IDX_W             = 2,
  parameter int LINE_W            = 12,
  parameter int EXP_LINES         = 1125,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input logic                 ACLK,
  input logic                 ARESETN,
  vsync_frame_detector_if.slave bus
);

  localparam logic IDLE_LVL = ~VSYNC_ACTIVE_HIGH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    RUN
  } state_t;

  logic [1:0]        vs_sync;
  logic [1:0]        hs_sync;
  logic              vs_lvl;
  logic              hs_lvl;
  logic              vs_dly;
  logic              hs_dly;
  logic              vs_edge;
  logic              hs_edge;
  state_t            state_q;
  logic              pulse_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] last_q;
  logic              locked_q;

  // Identical 3-register paths keep coincident vsync/hsync coincident
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vs_sync <= {2{IDLE_LVL}};
      hs_sync <= {2{IDLE_LVL}};
      vs_lvl  <= 1'b0;
      hs_lvl  <= 1'b0;
      vs_dly  <= 1'b0;
      hs_dly  <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[0], bus.vsync_in};
      hs_sync <= {hs_sync[0], bus.hsync_in};
      vs_lvl  <= vs_sync[1] ^ IDLE_LVL;
      hs_lvl  <= hs_sync[1] ^ IDLE_LVL;
      vs_dly  <= vs_lvl;
      hs_dly  <= hs_lvl;
    end
  end

  assign vs_edge = vs_lvl & ~vs_dly;
  assign hs_edge = hs_lvl & ~hs_dly;

  assign idx_nxt = (idx_q == IDX_W'(NUM_FRAMES - 1))
                 ? '0 : idx_q + 1'b1;

`ifdef VSYNC_FRAME_DET_LINE_CHECK_EN
  logic [1:0] match_q;
  logic       line_bad;
  logic       frame_end;
  logic       err_q;

  assign line_bad  = (line_q != LINE_W'(EXP_LINES));
  assign frame_end = bus.enable && (state_q == RUN) && vs_edge;

  // Sticky error; a new mismatch outranks a same-cycle clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (frame_end & line_bad) | (err_q & ~bus.err_clr);
    end
  end

  assign bus.frame_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg    = bus.err_clr | (EXP_LINES < 0);
  assign bus.frame_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= IDLE;
      pulse_q  <= 1'b0;
      idx_q    <= '0;
      line_q   <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
`ifdef VSYNC_FRAME_DET_LINE_CHECK_EN
      match_q  <= '0;
`endif
    end else begin
      pulse_q <= 1'b0;
      if (!bus.enable) begin
        state_q  <= IDLE;
        idx_q    <= '0;
        line_q   <= '0;
        locked_q <= 1'b0;
`ifdef VSYNC_FRAME_DET_LINE_CHECK_EN
        match_q  <= '0;
`endif
      end else begin
        unique case (state_q)
          IDLE: state_q <= WAIT_VS;
          WAIT_VS: begin
            if (vs_edge) begin
              pulse_q <= 1'b1;
              idx_q   <= '0;
              line_q  <= LINE_W'(hs_edge);
              state_q <= RUN;
            end
          end
          RUN: begin
            if (vs_edge) begin
              pulse_q <= 1'b1;
              idx_q   <= idx_nxt;
              last_q  <= line_q;
              line_q  <= LINE_W'(hs_edge);
`ifdef VSYNC_FRAME_DET_LINE_CHECK_EN
              if (line_bad) begin
                locked_q <= 1'b0;
                match_q  <= '0;
              end else begin
                if (match_q != 2'd2) match_q <= match_q + 1'b1;
                if (match_q != 2'd0) locked_q <= 1'b1;
              end
`else
              locked_q <= 1'b1;
`endif
            end else if (hs_edge && (line_q != '1)) begin
              line_q <= line_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.frame_pulse   = pulse_q;
  assign bus.frame_idx     = idx_q;
  assign bus.line_cnt_last = last_q;
  assign bus.locked        = locked_q;

endmodule

// File: doc/vsync_frame_detector.md
# vsync_frame_detector

Upstream front-end for `frame_cnt_irq_gen`. Samples the video timing vsync/hsync for one HDMI output channel and reconstructs frame boundaries. On each accepted frame start it emits a one-cycle `frame_pulse` and a frame-buffer index, which `frame_cnt_irq_gen` counts and turns into interrupts. It also measures lines per frame and flags malformed frames, so software can detect loss of video lock.

## Interface
- `NUM_FRAMES`, 3: frame-buffer ring depth. Range 2..2^IDX_W.
- `IDX_W`, 2: width of `frame_idx`.
- `LINE_W`, 12: width of the line counters.
- `EXP_LINES`, 1125: expected total lines per frame (1080p60).
- `VSYNC_ACTIVE_HIGH`, 1: 1 = sync pulses active-high; 0 = sync inputs inverted before edge detection.

Ports:
- `ACLK`  in  1  sole clock. All logic is on its rising edge.
- `ARESETN`  in  1  asynchronous active-low reset.
- `vsync_in`  in  1  raw vsync, passed through a 2-flop synchronizer.
- `hsync_in`  in  1  raw hsync, passed through a 2-flop synchronizer.
- `enable`  in  1  run control, driven by a `frame_cnt_irq_gen` register bit.
- `err_clr`  in  1  single-cycle clear of `frame_err`.
- `frame_pulse`  out  1  one-cycle pulse at each accepted frame start.
- `frame_idx`  out  IDX_W  index of the frame that just started.
- `line_cnt_last`  out  LINE_W  line count of the last completed frame.
- `locked`  out  1  timing is stable.
- `frame_err`  out  1  sticky line-count mismatch.

## Operation
Input conditioning:
- Each input passes through a 2-flop synchronizer, then a polarity normalizer, then a delay register.
- Edge events are `vs_edge` and `hs_edge`, the rising edges of the active-level signals.

FSM states:
- IDLE: the reset state, and the state whenever `enable`=0. Line counter = 0, `frame_idx`=0, `locked`=0, no pulses.
- WAIT_VS: entered when `enable`=1. On the first `vs_edge`:
  - pulse `frame_pulse` with `frame_idx`=0;
  - line counter ← 0 (or ← 1 if `hs_edge` is coincident);
  - go to RUN.
  - `line_cnt_last` is not updated.
- RUN: each `hs_edge` increments the line counter, saturating at 2^LINE_W−1. On `vs_edge`:
  - `line_cnt_last` ← line counter;
  - line counter ← 0, or ← 1 if `hs_edge` is coincident (that line belongs to the new frame);
  - `frame_idx` ← `frame_idx`+1, wrapping NUM_FRAMES−1 → 0;
  - pulse `frame_pulse`;
  - run the frame check (see Configuration).
- `enable` falling in any state returns to IDLE on the next edge. A `vs_edge` in that same cycle is ignored.

Error handling:
- `frame_err` is sticky. It is cleared only by `err_clr` or reset, and is not cleared by `enable`=0.
- If a mismatch and `err_clr` occur in the same cycle, set wins.

## Timing
- All outputs are registered. Reset values: `frame_pulse`=0, `frame_idx`=0, `line_cnt_last`=0, `locked`=0, `frame_err`=0. The FSM resets to IDLE.
- Latency: a sync input first sampled active at edge N produces its event, and the resulting output update, visible after edge N+3.
- vsync and hsync take identical paths, so coincident raw edges stay coincident.
- `frame_pulse` is high exactly one cycle per accepted `vs_edge`. It never stays high for 2 consecutive cycles.
- `frame_idx` and `line_cnt_last` change in the same cycle `frame_pulse` rises, and are stable while it is high.
- Minimum sync pulse width: 1 ACLK cycle. Minimum low gap between pulses: 1 cycle.
- An asynchronous reset assertion mid-frame immediately forces all reset values.

## Configuration
Macro: `VSYNC_FRAME_DET_LINE_CHECK_EN`.

Defined:
- At each RUN `vs_edge`, compare the completed line count with EXP_LINES.
- Mismatch: set `frame_err`, clear `locked`, clear the match counter.
- Match: increment the match counter. `locked` ← 1 after 2 consecutive matching frames.

Undefined:
- No comparison; `frame_err` is tied to 0.
- `locked` ← 1 at the first RUN `vs_edge` (first completed frame).
- `line_cnt_last` is still reported.

## Test plan
Bench overrides: EXP_LINES=4, NUM_FRAMES=3, macro defined unless stated.
- Reset, `enable`=1, then 5 frames of 4 hsync each:
  - 5 `frame_pulse`, idx sequence 0,1,2,0,1;
  - `line_cnt_last`=4 from pulse 2;
  - `locked`=1 after pulse 3;
  - `frame_err`=0.
- Locked stream, then one frame with 3 hsync:
  - at the next pulse `line_cnt_last`=3, `frame_err`=1, `locked`=0;
  - 2 further good frames give `locked`=1 with `frame_err` still 1;
  - `err_clr` gives `frame_err`=0.
- hsync and vsync raised on the same edge:
  - `line_cnt_last` counts that line in the new frame (4, not 5);
  - pulse appears 3 cycles after sampling.
- `enable` dropped mid-frame, restored 10 cycles later:
  - `locked`=0 and `frame_idx`=0;
  - next vsync gives a pulse with idx 0 and no `line_cnt_last` update.
- `ARESETN` asserted mid-frame with `frame_err`=1: all outputs are immediately 0.
- Macro undefined, 3-hsync frames: `frame_err` stays 0, `locked`=1 after the first completed frame.
